// File: rtl/gf571_mul_seq_if.sv
// Operand/result handshake and external 71x71 carry-less multiplier port bundle
// for the sequential GF(2^571) multiplier.
interface gf571_mul_seq_if;
  logic         start;
  logic [570:0] a;
  logic [570:0] b;
  logic         busy;
  logic         done;
  logic [570:0] d;
  logic [70:0]  mul_a;
  logic [70:0]  mul_b;
  logic [141:0] mul_d;

  modport master (
    output start, a, b, mul_d,
    input  busy, done, d, mul_a, mul_b
  );

  modport slave (
    input  start, a, b, mul_d,
    output busy, done, d, mul_a, mul_b
  );
endinterface

// File: rtl/gf571_mul_seq.sv
// Digit-serial GF(2^571) multiplier: 81 digit products through an external
// 1-stage 71x71 carry-less multiplier, then two folds modulo x^571+x^10+x^5+x^2+1.
module gf571_mul_seq (
  input  logic           clk,
  input  logic           rst,
  gf571_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RED1, RED2} state_e;

  state_e        state_q, state_d;
  logic [570:0]  a_q, a_d;
  logic [570:0]  b_q, b_d;
  logic [570:0]  d_q, d_d;
  logic [1140:0] acc_q, acc_d;
  logic [3:0]    i_q, i_d;
  logic [3:0]    j_q, j_d;
  logic          vld_q, vld_d;
  logic [4:0]    sh_q, sh_d;
  logic          done_q, done_d;

  logic [638:0]  a_ext, b_ext;
  logic [1140:0] prod_sh;
  logic [569:0]  hi;
  logic [1140:0] hi_ext;
  logic [1140:0] folded;
  logic [70:0]   mul_a_c, mul_b_c;

  assign a_ext = {68'd0, a_q};
  assign b_ext = {68'd0, b_q};

  // Product returned this cycle belongs to the pair issued last cycle (sh_q).
  assign prod_sh = 1141'(bus.mul_d) << (11'(sh_q) * 11'd71);

  assign hi     = acc_q[1140:571];
  assign hi_ext = {571'd0, hi};
  assign folded = {570'd0, acc_q[570:0]} ^ hi_ext ^ (hi_ext << 2)
                ^ (hi_ext << 5) ^ (hi_ext << 10);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    vld_d   = 1'b0;
    sh_d    = sh_q;
    done_d  = 1'b0;
    mul_a_c = '0;
    mul_b_c = '0;

    if (vld_q) begin
      acc_d = acc_q ^ prod_sh;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      ISSUE: begin
        mul_a_c = a_ext[10'(i_q) * 10'd71 +: 71];
        mul_b_c = b_ext[10'(j_q) * 10'd71 +: 71];
        vld_d   = 1'b1;
        sh_d    = 5'(i_q) + 5'(j_q);
        if (j_q == 4'd8) begin
          j_d = '0;
          if (i_q == 4'd8) begin
            i_d     = '0;
            state_d = DRAIN;
          end else begin
            i_d = i_q + 4'd1;
          end
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      DRAIN: begin
        state_d = RED1;
      end
      RED1: begin
        acc_d   = folded;
        state_d = RED2;
      end
      RED2: begin
        acc_d   = folded;
        d_d     = folded[570:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      vld_q   <= 1'b0;
      sh_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      vld_q   <= vld_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.d     = d_q;
  assign bus.mul_a = mul_a_c;
  assign bus.mul_b = mul_b_c;
endmodule
